// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, word/byte-enable
// widths and the wait-counter width.
package dmem_pkg;

    localparam int WORD_W = 32;
    localparam int BE_W   = 4;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/dmem_array.sv
// Word storage with a byte-enable synchronous write port and a registered read port.
// Optional DMEM_INIT_EN gives the array a defined initial image at time 0.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH     = 256,
    parameter int IDX_W     = 8,
    parameter     INIT_FILE = "dmem.hex"
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic              re,
    input  logic              clr,
    input  logic [IDX_W-1:0]  idx,
    input  logic [WORD_W-1:0] wdata,
    input  logic [BE_W-1:0]   be,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [WORD_W-1:0] rdata_d;
    logic [WORD_W-1:0] rdata_q;

`ifdef DMEM_INIT_EN
    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = '0;
        end
    end
`else
    // Contents are undefined until the first store to each word.
`endif

    // Read data doubles as the response data register: loaded on a load, cleared otherwise.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[idx];
        end else if (clr) begin
            rdata_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < BE_W; i++) begin
            if (we && be[i]) begin
                mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Target side of the processor load/store port: one request at a time, programmable
// wait latency, byte-enable stores. Optional array preload via DMEM_INIT_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int DEPTH     = 256,
    parameter int LATENCY   = 2,
    parameter     INIT_FILE = "dmem.hex"
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [WORD_W-1:0] resp_rdata,
    output logic              resp_err
);

    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WIDX_W = ADDR_W - 2;

    // Handshakes: a transfer happens on an edge where valid && ready; the initiator holds
    // its payload stable while valid is high and ready is low, and ready never waits on valid.
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_err_q, resp_err_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic [BE_W-1:0]   be_q, be_d;

    logic [WIDX_W-1:0] word_idx;
    logic              addr_err;
    logic              mem_we, mem_re, mem_clr;

    assign word_idx = addr_q[ADDR_W-1:2];
    assign addr_err = (addr_q[1:0] != 2'b00) || (int'(word_idx) >= DEPTH);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        resp_err_d   = resp_err_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        mem_we       = 1'b0;
        mem_re       = 1'b0;
        mem_clr      = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid && req_ready_q) begin
                    we_d        = req_we;
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    be_d        = req_be;
                    req_ready_d = 1'b0;
                    if (LATENCY == 0) begin
                        state_d = S_RESP;
                    end else begin
                        cnt_d   = CNT_W'(LATENCY);
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                // First RESP cycle performs the access; the response then holds until taken.
                if (!resp_valid_q) begin
                    resp_valid_d = 1'b1;
                    resp_err_d   = addr_err;
                    mem_we       = !addr_err && we_q;
                    mem_re       = !addr_err && !we_q;
                    mem_clr      = addr_err || we_q;
                end else if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    resp_err_d   = 1'b0;
                    mem_clr      = 1'b1;
                    req_ready_d  = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
        end
    end

    dmem_array #(
        .DEPTH     (DEPTH),
        .IDX_W     (IDX_W),
        .INIT_FILE (INIT_FILE)
    ) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (mem_we && rst_n),
        .re    (mem_re && rst_n),
        .clr   (mem_clr),
        .idx   (word_idx[IDX_W-1:0]),
        .wdata (wdata_q),
        .be    (be_q),
        .rdata (resp_rdata)
    );

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed and randomized checks of dmem_responder against a bench-side word model,
// with expected responses queued at request time and compared at response time.
module tb_dmem_responder;

    localparam int ADDR_W  = 11;
    localparam int DEPTH   = 256;
    localparam int LATENCY = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_we = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [31:0]       req_wdata = '0;
    logic [3:0]        req_be = '0;
    logic              resp_ready = 1'b0;
    logic              req_ready;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    logic [32:0] exp_q[$];
    logic [31:0] mem_m [DEPTH];
    int          n_vec = 0;
    int          n_mis = 0;

    dmem_responder #(
        .ADDR_W    (ADDR_W),
        .DEPTH     (DEPTH),
        .LATENCY   (LATENCY),
        .INIT_FILE ("dmem.hex")
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_be     (req_be),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full transaction from idle: accept, latency, optional backpressure, handshake.
    task automatic xact(input logic we, input logic [ADDR_W-1:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input int hold);
        logic        err;
        logic [32:0] exp;
        logic [31:0] held;
        int          n;
        int          idx;
        idx = int'(addr[ADDR_W-1:2]);
        err = (addr[1:0] != 2'b00) || (idx >= DEPTH);
        if (err) begin
            exp = {1'b1, 32'h0};
        end else if (we) begin
            exp = {1'b0, 32'h0};
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem_m[idx][8*i +: 8] = wdata[8*i +: 8];
            end
        end else begin
            exp = {1'b0, mem_m[idx]};
        end
        exp_q.push_back(exp);

        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("accept_wait", 64'(n), 64'd0);
        step();
        req_valid = 1'b0;
        chk("req_ready_drop", 64'(req_ready), 64'd0);

        n = 0;
        while (resp_valid !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        chk("latency", 64'(n), 64'(LATENCY + 1));

        held = resp_rdata;
        for (int k = 0; k < hold; k++) begin
            step();
            chk("bp_valid", 64'(resp_valid), 64'd1);
            chk("bp_rdata", 64'(resp_rdata), 64'(held));
            chk("bp_req_ready", 64'(req_ready), 64'd0);
        end

        exp = exp_q.pop_front();
        chk("rdata", 64'(resp_rdata), 64'(exp[31:0]));
        chk("err", 64'(resp_err), 64'(exp[32]));

        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        chk("hs_valid", 64'(resp_valid), 64'd0);
        chk("hs_err", 64'(resp_err), 64'd0);
        chk("hs_req_ready", 64'(req_ready), 64'd1);
    endtask

    initial begin
        // Reset held for two edges, then released.
        rst_n = 1'b0;
        step();
        chk("rst_req_ready_0", 64'(req_ready), 64'd0);
        chk("rst_resp_valid_0", 64'(resp_valid), 64'd0);
        step();
        chk("rst_req_ready_1", 64'(req_ready), 64'd0);
        chk("rst_resp_valid_1", 64'(resp_valid), 64'd0);
        rst_n = 1'b1;
        step();
        chk("rel_req_ready", 64'(req_ready), 64'd1);
        chk("rel_resp_valid", 64'(resp_valid), 64'd0);
        chk("rel_rdata", 64'(resp_rdata), 64'd0);
        chk("rel_err", 64'(resp_err), 64'd0);

        // Store then load.
        xact(1'b1, 11'h010, 32'hDEADBEEF, 4'hF, 0);
        xact(1'b0, 11'h010, 32'h0, 4'h0, 0);

        // Partial byte enables.
        xact(1'b1, 11'h020, 32'h11223344, 4'hF, 0);
        xact(1'b1, 11'h020, 32'hAABBCCDD, 4'b0101, 0);
        xact(1'b0, 11'h020, 32'h0, 4'h0, 0);

        // Misaligned load; out-of-range store must not alias onto word 0.
        xact(1'b0, 11'h013, 32'h0, 4'h0, 0);
        xact(1'b1, 11'h000, 32'h55AA55AA, 4'hF, 0);
        xact(1'b1, 11'h400, 32'hFFFFFFFF, 4'hF, 0);
        xact(1'b0, 11'h000, 32'h0, 4'h0, 0);

        // Zero byte-enable store is a no-op that still responds.
        xact(1'b1, 11'h010, 32'h01234567, 4'h0, 0);
        xact(1'b0, 11'h010, 32'h0, 4'h0, 0);

        // Backpressure, then back-to-back accept right after the handshake.
        xact(1'b0, 11'h010, 32'h0, 4'h0, 5);
        xact(1'b0, 11'h020, 32'h0, 4'h0, 0);

        // Reset while a store is waiting: the store must be dropped.
        xact(1'b1, 11'h030, 32'h12345678, 4'hF, 0);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 11'h030;
        req_wdata = 32'h0000CAFE;
        req_be    = 4'hF;
        step();
        req_valid = 1'b0;
        chk("mid_accept", 64'(req_ready), 64'd0);
        step();
        rst_n = 1'b0;
        step();
        chk("mid_rst_req_ready", 64'(req_ready), 64'd0);
        chk("mid_rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("mid_rst_rdata", 64'(resp_rdata), 64'd0);
        chk("mid_rst_err", 64'(resp_err), 64'd0);
        rst_n = 1'b1;
        step();
        chk("mid_rel_req_ready", 64'(req_ready), 64'd1);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("mid_no_resp", 64'(resp_valid), 64'd0);
        end
        xact(1'b0, 11'h030, 32'h0, 4'h0, 0);

        // Randomized traffic over words 16..31 after full initialization.
        for (int w = 16; w < 32; w++) begin
            xact(1'b1, ADDR_W'(w * 4), $urandom, 4'hF, 0);
        end
        for (int r = 0; r < 24; r++) begin
            xact(1'($urandom_range(0, 1)), ADDR_W'($urandom_range(16, 31) * 4), $urandom,
                 4'($urandom_range(0, 15)), $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
